// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: bus-side line refill engine for the BIU cache.
// Streams one line of word reads into the data array, then pulses line_refill.
module cache_refill_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int SEL_WIDTH = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    parameter int LINE_LSB  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_miss,
    input  logic [31:0]          miss_addr,
    input  logic [SEL_WIDTH-1:0] entry_replace_sel,
    output logic                 line_refill,
    output logic [31:0]          refill_pa,
    output logic                 refill_busy,
    output logic                 refill_err,
    output logic                 bus_req,
    output logic [31:0]          bus_addr,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_ack,
    input  logic                 bus_err,
    output logic                 line_wr_en,
    output logic [SEL_WIDTH-1:0] line_wr_sel,
    output logic [LINE_LSB-3:0]  line_wr_offset,
    output logic [31:0]          line_wr_data
);

    localparam int CW = LINE_LSB - 2;
    localparam int BW = 32 - LINE_LSB;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [BW-1:0]        base, base_nxt;
    logic [SEL_WIDTH-1:0] victim, victim_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 err_q, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            victim <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            base   <= base_nxt;
            victim <= victim_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        base_nxt    = base;
        victim_nxt  = victim;
        cnt_nxt     = cnt;
        err_nxt     = 1'b0;
        bus_req     = 1'b0;
        bus_addr    = '0;
        line_refill = 1'b0;
        unique case (state)
            IDLE: begin
                if (line_miss) begin
                    base_nxt   = miss_addr[31:LINE_LSB];
                    victim_nxt = entry_replace_sel;
                    cnt_nxt    = '0;
                    state_nxt  = FILL;
                end
            end
            FILL: begin
                bus_req  = 1'b1;
                bus_addr = {base, cnt, 2'b00};
                // An error beat wins over ack: abort without installing the tag.
                if (bus_err) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus_ack) begin
                    cnt_nxt = cnt + CW'(1);
                    if (&cnt) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                line_refill = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign refill_busy    = (state != IDLE);
    assign refill_err     = err_q;
    assign refill_pa      = {base, {LINE_LSB{1'b0}}};
    assign line_wr_en     = bus_req & bus_ack & ~bus_err;
    assign line_wr_sel    = victim;
    assign line_wr_offset = cnt;
    assign line_wr_data   = bus_rdata;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed bench for the refill engine.
// Four-word lines, table vectors plus hand-written multi-cycle sequences.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        line_miss;
    logic [31:0] miss_addr;
    logic [2:0]  entry_replace_sel;
    logic        line_refill;
    logic [31:0] refill_pa;
    logic        refill_busy;
    logic        refill_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        line_wr_en;
    logic [2:0]  line_wr_sel;
    logic [1:0]  line_wr_offset;
    logic [31:0] line_wr_data;

    int n_pass;
    int n_total;

    cache_refill_ctrl #(
        .ENTRY_NUM(8),
        .LINE_LSB (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .line_miss        (line_miss),
        .miss_addr        (miss_addr),
        .entry_replace_sel(entry_replace_sel),
        .line_refill      (line_refill),
        .refill_pa        (refill_pa),
        .refill_busy      (refill_busy),
        .refill_err       (refill_err),
        .bus_req          (bus_req),
        .bus_addr         (bus_addr),
        .bus_rdata        (bus_rdata),
        .bus_ack          (bus_ack),
        .bus_err          (bus_err),
        .line_wr_en       (line_wr_en),
        .line_wr_sel      (line_wr_sel),
        .line_wr_offset   (line_wr_offset),
        .line_wr_data     (line_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        miss;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        e_busy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [2:0]  e_sel;
        logic [1:0]  e_off;
        logic        e_ref;
        logic [31:0] e_pa;
        logic        e_rerr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_busy"}, refill_busy, 0);
        chk({p, "_req"}, bus_req, 0);
        chk({p, "_addr"}, bus_addr, 0);
        chk({p, "_wen"}, line_wr_en, 0);
        chk({p, "_ref"}, line_refill, 0);
        chk({p, "_pa"}, refill_pa, 0);
        chk({p, "_sel"}, line_wr_sel, 0);
        chk({p, "_off"}, line_wr_offset, 0);
        chk({p, "_rerr"}, refill_err, 0);
    endtask

    task automatic drive(input logic m, input logic [31:0] a,
                         input logic [2:0] s, input logic k,
                         input logic e);
        @(negedge clk);
        line_miss         = m;
        miss_addr         = a;
        entry_replace_sel = s;
        bus_ack           = k;
        bus_err           = e;
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive(0, 0, 0, 1, 0);
            if (!refill_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_idle", ok, 1);
    endtask

    initial begin
        int nwr;
        int nerr;
        int nref;
        int rcyc;
        n_pass            = 0;
        n_total           = 0;
        rst               = 1'b1;
        line_miss         = 1'b0;
        miss_addr         = '0;
        entry_replace_sel = '0;
        bus_rdata         = '0;
        bus_ack           = 1'b0;
        bus_err           = 1'b0;

        // miss, addr, sel, ack, err, rdata | busy, req, addr, wen, sel, off, ref, pa, rerr
        tbl[0] = '{1, 32'h1234, 5, 0, 0, 32'h0,
                   0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0};
        tbl[1] = '{0, 32'h0, 0, 1, 0, 32'hA0A0_0000,
                   1, 1, 32'h1230, 1, 5, 0, 0, 32'h1230, 0};
        tbl[2] = '{1, 32'h8000, 2, 1, 0, 32'hA0A0_0001,
                   1, 1, 32'h1234, 1, 5, 1, 0, 32'h1230, 0};
        tbl[3] = '{1, 32'h8000, 2, 1, 0, 32'hA0A0_0002,
                   1, 1, 32'h1238, 1, 5, 2, 0, 32'h1230, 0};
        tbl[4] = '{0, 32'h0, 0, 1, 0, 32'hA0A0_0003,
                   1, 1, 32'h123C, 1, 5, 3, 0, 32'h1230, 0};
        tbl[5] = '{0, 32'h0, 0, 0, 0, 32'h0,
                   1, 0, 32'h0, 0, 5, 0, 1, 32'h1230, 0};
        tbl[6] = '{0, 32'h0, 0, 1, 0, 32'h5555_5555,
                   0, 0, 32'h0, 0, 5, 0, 0, 32'h1230, 0};

        repeat (2) @(negedge clk);
        #1;
        chk_reset("rst");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst               = 1'b0;
            line_miss         = tbl[i].miss;
            miss_addr         = tbl[i].addr;
            entry_replace_sel = tbl[i].sel;
            bus_ack           = tbl[i].ack;
            bus_err           = tbl[i].err;
            bus_rdata         = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_busy", i), refill_busy, tbl[i].e_busy);
            chk($sformatf("v%0d_req", i), bus_req, tbl[i].e_req);
            chk($sformatf("v%0d_addr", i), bus_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_wen", i), line_wr_en, tbl[i].e_wen);
            chk($sformatf("v%0d_sel", i), line_wr_sel, tbl[i].e_sel);
            chk($sformatf("v%0d_off", i), line_wr_offset, tbl[i].e_off);
            chk($sformatf("v%0d_ref", i), line_refill, tbl[i].e_ref);
            chk($sformatf("v%0d_pa", i), refill_pa, tbl[i].e_pa);
            chk($sformatf("v%0d_rerr", i), refill_err, tbl[i].e_rerr);
            if (tbl[i].e_wen) begin
                chk($sformatf("v%0d_data", i), line_wr_data, tbl[i].rdata);
            end
        end

        // Wait states: ack every third cycle.
        drive(1, 32'h1234, 5, 0, 0);
        nwr  = 0;
        rcyc = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 0, (k % 3) == 0, 0);
            if (k <= 12) begin
                chk($sformatf("ws_addr%0d", k), bus_addr,
                    32'h1230 + 32'(4 * ((k - 1) / 3)));
            end
            if (line_wr_en) nwr++;
            if (line_refill && rcyc < 0) rcyc = k;
        end
        chk("ws_writes", nwr, 4);
        chk("ws_refill_cyc", rcyc, 13);

        // Bus error on beat 2 with the miss held.
        drive(1, 32'h2344, 6, 0, 0);
        nwr  = 0;
        nerr = 0;
        nref = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) drive(1, 32'h2344, 6, k <= 3, k == 3);
            else drive(0, 0, 0, 0, 0);
            if (line_wr_en) nwr++;
            if (refill_err) nerr++;
            if (line_refill) nref++;
            if (k == 4) chk("err_busy", refill_busy, 0);
            if (k == 5) begin
                chk("err_restart_req", bus_req, 1);
                chk("err_restart_addr", bus_addr, 32'h2340);
                chk("err_restart_off", line_wr_offset, 0);
                chk("err_restart_sel", line_wr_sel, 6);
            end
        end
        chk("err_writes", nwr, 2);
        chk("err_pulses", nerr, 1);
        chk("err_norefill", nref, 0);
        drain();

        // Reset asserted on beat 1.
        drive(1, 32'h3458, 4, 0, 0);
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_beat1_off", line_wr_offset, 1);
        @(negedge clk);
        rst     = 1'b0;
        bus_ack = 1'b0;
        #1;
        chk_reset("mrst");
        nref = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0);
            if (line_refill || refill_err || refill_busy) nref++;
        end
        chk("mrst_quiet", nref, 0);

        // Back-to-back misses.
        drive(1, 32'h1234, 5, 0, 0);
        for (int k = 1; k <= 4; k++) drive(0, 0, 0, 1, 0);
        drive(1, 32'h5678, 3, 0, 0);
        chk("b2b_ref1", line_refill, 1);
        chk("b2b_pa1", refill_pa, 32'h1230);
        drive(1, 32'h5678, 3, 0, 0);
        chk("b2b_idle_busy", refill_busy, 0);
        chk("b2b_idle_req", bus_req, 0);
        drive(0, 0, 0, 1, 0);
        chk("b2b_req2", bus_req, 1);
        chk("b2b_addr2", bus_addr, 32'h5670);
        chk("b2b_sel2", line_wr_sel, 3);
        for (int k = 8; k <= 11; k++) drive(0, 0, 0, k < 11, 0);
        chk("b2b_ref2", line_refill, 1);
        chk("b2b_pa2", refill_pa, 32'h5670);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
